ble_response_frame_receiver: RTL
================================

# ble_response_frame_receiver

Host-side receive stage that sits directly downstream of the BLE-side `uart_rx` (`data`/`valid`) and upstream of the host response encoder path. It locks onto a sync byte and assembles a fixed 18-byte (144-bit) response frame from the BLE slave. It enforces an inter-byte timeout and checks an XOR checksum. A good frame is presented with its response ID and payload fields, held under a valid/ack handshake.

## Interface
- `TIMEOUT`, 4000000: idle clocks allowed between bytes once a frame has started.
- `SYNC_BYTE`, 8'hA5: the first byte of every frame.
- `FRAME_BYTES`, 18: frame length in bytes, checksum byte included. Fixed; `frame` width is `8*FRAME_BYTES`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `soft_reset` in 1: synchronous clear to IDLE, same effect as reset.
- `rx_data` in 8: byte from `uart_rx`.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `frame` out 144: assembled frame. Byte 0 is at [143:136]; byte 17 is at [7:0].
- `rsp_id` out 16: frame bytes 1..2, byte 1 is the MSB.
- `payload` out 32: frame bytes 3..6, byte 3 is the MSB.
- `frame_valid` out 1: level signal, high while a checked frame is held.
- `frame_ack` in 1: consumer releases the held frame.
- `error` out 1: one-cycle pulse.
- `error_code` out 2: meaningful while `error` is high. 01 = timeout, 10 = checksum, 11 = overrun.
- `busy` out 1: high in COLLECT or CHECK.

## Operation
States and transitions:
- **IDLE**
  - `rx_valid` with `rx_data == SYNC_BYTE`: store as byte 0, set byte index to 1, set running XOR to `SYNC_BYTE`, go to COLLECT.
  - Any other byte is silently discarded.
- **COLLECT**
  - Each `rx_valid` stores the byte at the current index, XORs it into the running checksum, increments the index and clears the timeout counter.
  - The checksum byte (index 17) is stored but not folded into the XOR.
  - Storing index 17 moves to CHECK.
- **CHECK** (one cycle)
  - Running XOR of bytes 0..16 equals byte 17: go to HOLD and raise `frame_valid`.
  - Otherwise: pulse `error` with code 10 and return to IDLE.
- **HOLD**
  - `frame`, `rsp_id` and `payload` are stable.
  - `frame_ack`: drop `frame_valid`, go to IDLE.
  - `rx_valid` without `frame_ack`: pulse `error` with code 11, discard the byte, remain in HOLD.

Timeout:
- The counter runs only in COLLECT. It increments on every cycle without `rx_valid`.
- When the count reaches `TIMEOUT`: pulse `error` with code 01, discard the partial frame, go to IDLE.
- The counter is 32 bits.

Priority and boundary rules:
- Priority order: `reset` > `soft_reset` > everything else.
- `rx_valid` in the same cycle the count reaches `TIMEOUT`: the byte wins. It is stored, the counter clears and no error is raised.
- HOLD with `frame_ack` and `rx_valid` in the same cycle: the ack is taken and the byte is evaluated as in IDLE. If it is `SYNC_BYTE`, the next state is COLLECT with index 1.
- In COLLECT, a `SYNC_BYTE` value is ordinary data. There is no resync mid-frame.
- Reset or `soft_reset` mid-frame: discard the partial frame. No error pulse.

Reset values:
- `frame`, `rsp_id`, `payload`, `error_code` = 0.
- `frame_valid`, `error`, `busy` = 0.
- State IDLE, index 0, counter 0, running XOR 0.

## Timing
- All outputs are registered.
- The last byte is captured at edge t, entering CHECK. `frame_valid` rises at edge t+1.
- A checksum failure pulses `error` in the cycle after edge t+1.
- `frame`, `rsp_id` and `payload` update only on the edge that enters HOLD. They keep their values after the ack until the next good frame.
- `frame_ack` is sampled only in HOLD; it is ignored otherwise.
- `error` is high for exactly one cycle per event.
- Back-to-back bytes on consecutive cycles are accepted.
- Minimum frame-to-frame spacing is 18 `rx_valid` strobes plus CHECK plus the ack cycle.

## Structure
- Shared package `wic_frame_pkg` holds:
  - the constants `SYNC_BYTE`, `FRAME_BYTES` and `FRAME_W = 144`;
  - the error-code localparams `ERR_TIMEOUT`, `ERR_CHECKSUM`, `ERR_OVERRUN`;
  - the state encoding.
- One natural sub-module, `frame_idle_timer`: a clear/enable counter that raises `expired` when the count reaches `TIMEOUT`. It is shared with the host-side SPI-response timeout.
- The byte-store shift, checksum and FSM stay in this module.

## Test plan
- **Good frame:** send 0xA5, 0x00, 0x02, 0x12, 0x34, 0x56, 0x78, then ten 0x00 bytes, then the XOR of bytes 0..16. Required: `frame_valid` two edges after the last byte, `rsp_id = 16'h0002`, `payload = 32'h12345678`. After `frame_ack`, the block returns to IDLE.
- **Leading garbage:** send 0x11, 0x22, then a good frame. Required: the garbage is ignored, `error` never pulses, and the frame is delivered as in the good-frame case.
- **Bad checksum:** send a good frame with its last byte XOR 0x01. Required: one `error` pulse with code 10, `frame_valid` stays low, next state IDLE.
- **Timeout:** with `TIMEOUT = 50`, send 5 bytes then go idle. Required: code 01 after 50 idle cycles, next state IDLE.
- **Timeout race:** with `TIMEOUT = 50`, deliver a byte on the cycle the count reaches 50. Required: no error, and the frame completes normally.
- **Overrun, then ack race:** hold a good frame and send a byte without `frame_ack`. Required: code 01 is not raised; code 11 pulses and the frame data is unchanged. Then assert `frame_ack` together with 0xA5. Required: the block enters COLLECT at index 1.
- **Mid-frame reset:** assert `soft_reset` after 9 bytes. Required: all outputs return to their reset values, no error pulse. A following good frame is received correctly. Repeat the same check with async `reset`.

Source files
------------

// File: rtl/wic_frame_pkg.sv
// Shared constants for the host-side BLE/SPI response frame path:
// framing, error codes and receiver state encoding.
package wic_frame_pkg;

   localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
   localparam int unsigned FRAME_BYTES = 18;
   localparam int unsigned FRAME_W     = 144;
   localparam int unsigned IDX_W       = 5;

   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_CHECKSUM = 2'b10;
   localparam logic [1:0] ERR_OVERRUN  = 2'b11;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_CHECK   = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

endpackage

// File: rtl/frame_idle_timer.sv
// Clear/enable idle counter; expired_o is high while the count sits at TIMEOUT.
module frame_idle_timer #(
   parameter int unsigned TIMEOUT = 32'd4000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = 32;

   logic [CNT_W-1:0] count_q, count_d;

   // Saturates at TIMEOUT so a late consumer still sees expired_o.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != TIMEOUT)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         expired_o <= 1'b0;
      end else begin
         count_q   <= count_d;
         expired_o <= (count_d == TIMEOUT);
      end
   end

endmodule

// File: rtl/ble_response_frame_receiver.sv
// Locks onto the sync byte from uart_rx, assembles an 18-byte response frame,
// checks its XOR checksum and holds good frames under a valid/ack handshake.
module ble_response_frame_receiver
   import wic_frame_pkg::*;
#(
   parameter int unsigned TIMEOUT = 32'd4000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               soft_reset,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic [FRAME_W-1:0] frame,
   output logic [15:0]        rsp_id,
   output logic [31:0]        payload,
   output logic               frame_valid,
   input  logic               frame_ack,
   output logic               error,
   output logic [1:0]         error_code,
   output logic               busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [7:0]         xor_q, xor_d;
   logic [FRAME_W-1:0] buf_q, buf_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               error_q, error_d;
   logic [1:0]         error_code_q, error_code_d;
   logic               frame_valid_q, frame_valid_d;
   logic               busy_q, busy_d;
   logic               expired;

   frame_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (soft_reset || rx_valid || (state_q != ST_COLLECT)),
      .en_i      ((state_q == ST_COLLECT) && !rx_valid),
      .expired_o (expired)
   );

   // Next-state, byte shift-in and running checksum.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      xor_d        = xor_q;
      buf_d        = buf_q;
      frame_d      = frame_q;
      error_d      = 1'b0;
      error_code_d = error_code_q;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               buf_d   = {(FRAME_W-8)'(0), SYNC_BYTE};
               idx_d   = IDX_W'(1);
               xor_d   = SYNC_BYTE;
               state_d = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (rx_valid) begin
               buf_d = {buf_q[FRAME_W-9:0], rx_data};
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  state_d = ST_CHECK;
               end else begin
                  xor_d = xor_q ^ rx_data;
               end
            end else if (expired) begin
               error_d      = 1'b1;
               error_code_d = ERR_TIMEOUT;
               idx_d        = '0;
               xor_d        = '0;
               state_d      = ST_IDLE;
            end
         end
         ST_CHECK: begin
            idx_d = '0;
            xor_d = '0;
            if (xor_q == buf_q[7:0]) begin
               frame_d = buf_q;
               state_d = ST_HOLD;
            end else begin
               error_d      = 1'b1;
               error_code_d = ERR_CHECKSUM;
               state_d      = ST_IDLE;
            end
         end
         ST_HOLD: begin
            // On ack the same-cycle byte is treated exactly as in IDLE.
            if (frame_ack) begin
               state_d = ST_IDLE;
               if (rx_valid && (rx_data == SYNC_BYTE)) begin
                  buf_d   = {(FRAME_W-8)'(0), SYNC_BYTE};
                  idx_d   = IDX_W'(1);
                  xor_d   = SYNC_BYTE;
                  state_d = ST_COLLECT;
               end
            end else if (rx_valid) begin
               error_d      = 1'b1;
               error_code_d = ERR_OVERRUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      frame_valid_d = (state_d == ST_HOLD);
      busy_d        = (state_d == ST_COLLECT) || (state_d == ST_CHECK);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         xor_q         <= '0;
         buf_q         <= '0;
         frame_q       <= '0;
         error_q       <= 1'b0;
         error_code_q  <= '0;
         frame_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else if (soft_reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         xor_q         <= '0;
         buf_q         <= '0;
         frame_q       <= '0;
         error_q       <= 1'b0;
         error_code_q  <= '0;
         frame_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         xor_q         <= xor_d;
         buf_q         <= buf_d;
         frame_q       <= frame_d;
         error_q       <= error_d;
         error_code_q  <= error_code_d;
         frame_valid_q <= frame_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign frame       = frame_q;
   assign rsp_id      = frame_q[FRAME_W-9 -: 16];
   assign payload     = frame_q[FRAME_W-25 -: 32];
   assign frame_valid = frame_valid_q;
   assign error       = error_q;
   assign error_code  = error_code_q;
   assign busy        = busy_q;

endmodule
